// File: rtl/shared_dmem_arbiter_if.sv
// Requester-side bundle for the shared data RAM: per-port request fields
// packed into flat vectors, with registered completion signals.
interface shared_dmem_arbiter_if #(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32
);
    localparam int BW = DATA_W / 8;

    logic [NUM_PORTS-1:0]        req;
    logic [NUM_PORTS-1:0]        we;
    logic [NUM_PORTS*BW-1:0]     be;
    logic [NUM_PORTS*ADDR_W-1:0] addr;
    logic [NUM_PORTS*DATA_W-1:0] wdata;
    logic [NUM_PORTS-1:0]        ready;
    logic [NUM_PORTS*DATA_W-1:0] rdata;
    logic [NUM_PORTS-1:0]        err;

    modport master (
        output req, we, be, addr, wdata,
        input  ready, rdata, err
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output ready, rdata, err
    );
endinterface

// File: rtl/shared_dmem_arbiter.sv
// Word-organised single-port data RAM shared by NUM_PORTS requesters.
// Round-robin by default; define ARB_FIXED_PRIORITY_EN for lowest-index-wins.
module shared_dmem_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    shared_dmem_arbiter_if.slave  bus
);
    localparam int BW  = DATA_W / 8;
    localparam int OFF = (BW > 1) ? $clog2(BW) : 0;
    localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int RW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                        gnt_vld;
    logic [PW-1:0]               gnt;

    logic                        sel_we;
    logic [BW-1:0]               sel_be;
    logic [ADDR_W-1:0]           sel_addr;
    logic [DATA_W-1:0]           sel_wdata;
    logic [ADDR_W-1:0]           widx;
    logic                        in_range;
    logic [RW-1:0]               ridx;

    logic [DATA_W-1:0]           mem [DEPTH];

    logic [NUM_PORTS-1:0]        ready_q;
    logic [NUM_PORTS-1:0]        err_q;
    logic [NUM_PORTS*DATA_W-1:0] rdata_q;

`ifdef ARB_FIXED_PRIORITY_EN
    // Descending scan so the lowest requesting index is the final winner
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                gnt_vld = 1'b1;
                gnt     = PW'(i);
            end
        end
    end
`else
    logic [PW-1:0] last_grant;
    int            cand;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= PW'(NUM_PORTS - 1);
        end else if (gnt_vld) begin
            last_grant <= gnt;
        end
    end

    // Search starts just after the previous winner and wraps
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        cand    = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = (int'(last_grant) + 1 + i) % NUM_PORTS;
            if (!gnt_vld && bus.req[cand]) begin
                gnt_vld = 1'b1;
                gnt     = PW'(cand);
            end
        end
    end
`endif

    always_comb begin
        sel_we    = bus.we[gnt];
        sel_be    = bus.be[gnt*BW +: BW];
        sel_addr  = bus.addr[gnt*ADDR_W +: ADDR_W];
        sel_wdata = bus.wdata[gnt*DATA_W +: DATA_W];
        widx      = sel_addr >> OFF;
        // Full-width compare: upper address bits never alias into the array
        in_range  = 64'(widx) < 64'(DEPTH);
        ridx      = widx[RW-1:0];
    end

    // Writes are suppressed while reset is held so an aborted access is lost
    always_ff @(posedge clk) begin
        if (!reset && gnt_vld && sel_we && in_range) begin
            for (int i = 0; i < BW; i++) begin
                if (sel_be[i]) begin
                    mem[ridx][i*8 +: 8] <= sel_wdata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q <= '0;
            err_q   <= '0;
            rdata_q <= '0;
        end else begin
            ready_q <= '0;
            err_q   <= '0;
            if (gnt_vld) begin
                ready_q[gnt] <= 1'b1;
                err_q[gnt]   <= !in_range;
                rdata_q[gnt*DATA_W +: DATA_W] <=
                    (in_range && !sel_we) ? mem[ridx] : '0;
            end
        end
    end

    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_shared_dmem_arbiter.sv
// Scoreboard bench for shared_dmem_arbiter: expectations are queued on
// issue and popped when a ready pulse appears.
module tb_shared_dmem_arbiter;
    localparam int NP    = 2;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 64;
    localparam int BW    = DW / 8;

    typedef struct {
        int          port;
        logic [DW-1:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    shared_dmem_arbiter_if #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW)) bus();

    shared_dmem_arbiter #(
        .NUM_PORTS(NP),
        .DATA_W(DW),
        .ADDR_W(AW),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    exp_t          sbq [$];
    logic [DW-1:0] model [int];
    int            checks = 0;
    int            errors = 0;
    bit            mon_en = 1'b0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_port(int p, bit r, bit w, logic [BW-1:0] b,
                            logic [AW-1:0] a, logic [DW-1:0] d);
        bus.req[p]             = r;
        bus.we[p]              = w;
        bus.be[p*BW +: BW]     = b;
        bus.addr[p*AW +: AW]   = a;
        bus.wdata[p*DW +: DW]  = d;
    endtask

    task automatic push_exp(int p, bit w, logic [BW-1:0] b,
                            logic [AW-1:0] a, logic [DW-1:0] d);
        exp_t          e;
        logic [AW-1:0] wi;
        logic [DW-1:0] old;
        int            idx;
        wi      = a >> 2;
        idx     = int'(wi);
        e.port  = p;
        e.err   = 1'b0;
        e.rdata = '0;
        if (wi >= AW'(DEPTH)) begin
            e.err = 1'b1;
        end else if (w) begin
            old = model.exists(idx) ? model[idx] : 'x;
            for (int i = 0; i < BW; i++)
                if (b[i]) old[i*8 +: 8] = d[i*8 +: 8];
            model[idx] = old;
        end else begin
            e.rdata = model[idx];
        end
        sbq.push_back(e);
    endtask

    // Single request on port p, held until its ready pulse
    task automatic access(int p, bit w, logic [BW-1:0] b,
                          logic [AW-1:0] a, logic [DW-1:0] d);
        bit got;
        got = 1'b0;
        push_exp(p, w, b, a, d);
        set_port(p, 1'b1, w, b, a, d);
        for (int n = 0; n < 20 && !got; n++) begin
            @(posedge clk);
            #1;
            if (bus.ready[p]) got = 1'b1;
        end
        if (!got) chk("timeout", 64'd0, 64'd1);
        set_port(p, 1'b0, 1'b0, '0, '0, '0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !reset && bus.ready != '0) begin
            chk("onehot", 64'($countones(bus.ready)), 64'd1);
            if (sbq.size() == 0) begin
                chk("unexpected_ready", 64'(bus.ready), 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("port", 64'(bus.ready), 64'(1 << e.port));
                chk("rdata", 64'(bus.rdata[e.port*DW +: DW]), 64'(e.rdata));
                chk("err", 64'(bus.err[e.port]), 64'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        bus.req   = '0;
        bus.we    = '0;
        bus.be    = '0;
        bus.addr  = '0;
        bus.wdata = '0;

        #12;
        chk("rst_ready", 64'(bus.ready), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        chk("rst_rdata", 64'(bus.rdata), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Basic write/read and back-to-back hazard
        access(0, 1'b1, 4'hF, 32'h0000_0000, 32'h0102_0304);
        access(0, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
        access(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0);

        // Byte enables, no-op write, ignored offset bits
        access(1, 1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344);
        access(1, 1'b1, 4'h5, 32'h0000_0020, 32'hAABB_CCDD);
        access(1, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
        access(0, 1'b1, 4'h0, 32'h0000_0020, 32'hFFFF_FFFF);
        access(0, 1'b0, 4'hF, 32'h0000_0023, 32'h0);

        // Range boundaries and no aliasing
        access(1, 1'b1, 4'hF, 32'(DEPTH*4 - 4), 32'h7777_8888);
        access(1, 1'b0, 4'hF, 32'(DEPTH*4 - 4), 32'h0);
        access(1, 1'b1, 4'hF, 32'(DEPTH*4), 32'h5A5A_5A5A);
        access(1, 1'b1, 4'hF, 32'h8000_0000, 32'h5A5A_5A5A);
        access(0, 1'b0, 4'hF, 32'h0000_0000, 32'h0);
        access(0, 1'b0, 4'hF, 32'h8000_0000, 32'h0);

        // Async reset in the middle of an outstanding write
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b0;
        set_port(0, 1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
        @(posedge clk);
        #1;
        chk("t5_ready_pre", 64'(bus.ready), 64'd1);
        chk("t5_rdata_pre", 64'(bus.rdata[0 +: DW]), 64'hDEAD_BEEF);
        set_port(0, 1'b1, 1'b1, 4'hF, 32'h0000_0010, 32'hCAFE_F00D);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_ready", 64'(bus.ready), 64'd0);
        chk("t5_err", 64'(bus.err), 64'd0);
        chk("t5_rdata", 64'(bus.rdata), 64'd0);
        @(posedge clk);
        #1;
        set_port(0, 1'b0, 1'b0, '0, '0, '0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        mon_en = 1'b1;

        // Both ports requesting continuously straight after reset
`ifdef ARB_FIXED_PRIORITY_EN
        for (int k = 0; k < 4; k++)
            push_exp(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
        push_exp(1, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
        set_port(0, 1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
        set_port(1, 1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        set_port(0, 1'b0, 1'b0, '0, '0, '0);
        @(posedge clk);
        #1;
        set_port(1, 1'b0, 1'b0, '0, '0, '0);
`else
        for (int k = 0; k < 3; k++) begin
            push_exp(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
            push_exp(1, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
        end
        set_port(0, 1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
        set_port(1, 1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
        repeat (6) @(posedge clk);
        #1;
        set_port(0, 1'b0, 1'b0, '0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0, '0);
`endif

        repeat (4) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shared_dmem_arbiter.md
Name: shared_dmem_arbiter

Overview:
Parametrised successor of the single-core data memory. It is a word-organised, single-ported data RAM shared by NUM_PORTS requesters, such as multiple Core instances or a core plus a DMA engine.
- Per-port valid/ready handshake.
- Round-robin arbitration, one access per clock.
- Byte-enable writes.
- Out-of-range error reporting.
- Sits between the core(s) and the data RAM in the SoC top.

Parameters:
NUM_PORTS, 2, number of requester ports (1..8)
DATA_W, 32, data word width in bits (multiple of 8)
ADDR_W, 32, byte address width per port
DEPTH, 1024, RAM depth in words (power of two not required)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
req  input  NUM_PORTS  per-port request valid; held until matching ready
we  input  NUM_PORTS  per-port write enable (1 = write, 0 = read)
be  input  NUM_PORTS*DATA_W/8  per-port byte enables, port p at [p*DATA_W/8 +: DATA_W/8]; ignored for reads
addr  input  NUM_PORTS*ADDR_W  per-port byte address, port p at [p*ADDR_W +: ADDR_W]
wdata  input  NUM_PORTS*DATA_W  per-port write data
ready  output  NUM_PORTS  one-cycle completion pulse, registered
rdata  output  NUM_PORTS*DATA_W  per-port read data, valid only while ready[p]=1, registered
err  output  NUM_PORTS  out-of-range flag, valid with ready[p], registered

Behaviour:
Reset and reset values:
- Reset is asynchronous and active-high; clk is the single clock.
- Reset clears ready, rdata and err to 0, and sets the RR pointer (last_grant) to NUM_PORTS-1, so port 0 wins first.
- RAM contents are not reset.
- Reset asserted mid-transaction aborts it: no ready is issued, and any write not yet committed at a clock edge is lost.

Arbitration (combinational, each cycle):
- Candidates are ports with req[p]=1.
- The search order starts at (last_grant+1) mod NUM_PORTS and wraps.
- The first candidate found is granted (g). At most one grant per cycle.
- last_grant <= g on every cycle with a grant; otherwise it holds.

Access (rising edge ending grant cycle T):
- Word index = addr_g >> log2(DATA_W/8); low byte-offset bits are ignored (no misalignment fault).
- Index < DEPTH, write: byte lane i is written iff be_g[i]=1; be=0 is a legal no-op write; rdata_g <= 0.
- Index < DEPTH, read: rdata_g <= RAM[index], i.e. the old contents.
- Index >= DEPTH: no RAM update, rdata_g <= 0, err_g <= 1.

Response timing:
- In cycle T+1: ready[g]=1 and err[g] is valid. All other ready bits are 0. ready is a single-cycle pulse.
- Latency from grant to ready is 1 cycle. Throughput is 1 access per cycle aggregate.
- Requester protocol: hold req, we, be, addr and wdata stable until ready[p]. In the ready cycle the requester may drop req or present a new request, which is eligible in that same cycle.
- An ungranted port keeps waiting with no timeout. Starvation bound is NUM_PORTS-1 cycles.

Hazards and boundaries:
- A read in cycle T+1 to the address written in cycle T returns the new data.
- Write-read ordering between ports follows grant order.
- NUM_PORTS=1: arbiter degenerates to always grant port 0 while req=1.
- rdata of non-ready ports holds its last value and is don't-care to requesters.
- ADDR_W bits above the index are included in the range check, so aliasing is never permitted.

Optional Feature:
ARB_FIXED_PRIORITY_EN
- Defined: fixed priority, lowest port index wins every cycle. The last_grant register is removed, and starvation of high indices is permitted.
- Undefined (default): round-robin as specified above.

Test Plan:
1. Reset, then port0 writes addr 0x10 with wdata 0xDEADBEEF and be=4'hF. Next request: port0 reads 0x10. Required: ready[0] the cycle after each grant, read rdata=0xDEADBEEF, err=0.
2. Byte enables: write 0x11223344 to 0x20 with be=F, then write 0xAABBCCDD with be=4'b0101. Required: readback 0x11BB33DD.
3. Both ports hold req continuously (reads) for 6 cycles after reset. Required: grant order 0,1,0,1,0,1, with exactly one ready bit per cycle.
4. Out-of-range: port1 writes addr DEPTH*4 with wdata 0x5A5A5A5A. Required: ready[1]=1, err[1]=1, rdata=0. A subsequent read of word 0 is unchanged (no wrap).
5. Reset asserted asynchronously while port0 req is high, between grant and edge. Required: ready=0, err=0, rdata=0 immediately. After release, port0 is granted first.
6. With ARB_FIXED_PRIORITY_EN defined and both ports requesting continuously: port0 is granted every cycle. Port1 is granted only in cycles where port0 drops req.
